ahb_byte_master: RTL and testbench
==================================

AHB_BYTE_MASTER -- requirements
Module: ahb_byte_master

Purpose: byte-stream command bridge driving the second AHB master port of the interconnect, for host load/peek of RAM and peripherals over a UART byte link.

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CMD_WR, 8'h57, write-word command byte.
- CMD_RD, 8'h52, read-word command byte.
- ACK, 8'h06, write-OK response byte.
- NAK, 8'h15, error response byte.

REQ-002 Ports, one per line (name, direction, width, meaning):
- hclk, in, 1, sole clock.
- hreset, in, 1, reset: synchronous, active-high.
- rx_data, in, 8, inbound byte.
- rx_valid, in, 1, rx_data valid.
- rx_ready, out, 1, byte accepted when rx_valid && rx_ready.
- tx_data, out, 8, outbound byte.
- tx_valid, out, 1, tx_data valid.
- tx_ready, in, 1, byte consumed when tx_valid && tx_ready.
- hbusreq, out, 1, AHB bus request.
- hgrant, in, 1, AHB grant.
- haddr, out, 32, AHB address.
- htrans, out, 2, AHB transfer type.
- hsize, out, 3, AHB size.
- hburst, out, 3, AHB burst.
- hprot, out, 4, AHB protection.
- hwrite, out, 1, AHB write.
- hwdata, out, 32, AHB write data.
- hmasterlock, out, 1, AHB lock.
- hrdata, in, 32, AHB read data.
- hready, in, 1, AHB ready.
- hresp, in, 2, AHB response.
- busy, out, 1, high whenever state != IDLE.

Function
REQ-003 Constant outputs: hsize=3'b010, hburst=3'b000, hprot=4'b0011, hmasterlock=0.
REQ-004 Alignment: haddr[1:0] shall always be 2'b00.
REQ-005 FSM states: IDLE, ADDR, DATA, REQ, APH, DPH, RESP.
REQ-006 IDLE: rx_ready=1.
- Byte == CMD_WR or CMD_RD: latch direction, go to ADDR.
- Any other byte: consumed and discarded, stay IDLE.
REQ-007 ADDR: rx_ready=1; collect 4 bytes little-endian (first byte = addr[7:0]) with a 2-bit counter. After the 4th byte: write -> DATA, read -> REQ.
REQ-008 DATA: rx_ready=1; collect 4 bytes little-endian into the write-data register; after the 4th byte -> REQ.
REQ-009 rx_ready shall be 0 in REQ, APH, DPH, RESP; no rx byte is lost or reordered.
REQ-010 REQ: hbusreq=1, htrans=IDLE. On an edge with hgrant && hready -> APH.
REQ-011 APH: htrans=NONSEQ; haddr/hwrite valid; hbusreq=0.
- hready=1 at edge: -> DPH.
- hready=0: hold all address-phase signals.
REQ-012 DPH: htrans=IDLE; hwdata = write-data register (write); hold until an edge with hready=1. At that edge capture hrdata and hresp, then act on hresp:
- OKAY (00) or ERROR (01): -> RESP.
- RETRY (10) or SPLIT (11): -> REQ and reissue the identical transfer.
REQ-013 ERROR two-cycle response: the first cycle (hready=0, hresp=01) shall not end the data phase; only the hready=1 cycle is sampled.
REQ-014 RESP: tx_valid=1; advance on each tx_valid && tx_ready.
- Read OKAY: 4 bytes, hrdata[7:0] first.
- Write OKAY: single ACK.
- Any ERROR: single NAK, with no data bytes.
- Last byte accepted: -> IDLE.
REQ-015 tx_data stable while tx_valid && !tx_ready; tx_valid=0 outside RESP.
REQ-016 Minimum latency, read with immediate grant and zero-wait slave: last address byte accepted -> first tx byte valid in 4 cycles (REQ, APH, DPH, RESP).

Reset
REQ-017 On hreset=1 at an edge, in any state, including mid-transfer:
- State -> IDLE; byte counters cleared; partial command discarded.
- Outputs: hbusreq=0, htrans=2'b00, haddr=0, hwrite=0, hwdata=0, rx_ready=0 during reset, tx_valid=0, tx_data=0, busy=0.
REQ-018 First cycle after hreset deasserts: rx_ready=1.

Verification
REQ-019 Write: stream 57 00 00 00 20 EF BE AD DE with hgrant=1 and a zero-wait slave.
- Required: one NONSEQ write, haddr=0x20000000, hwdata=0xDEADBEEF.
- tx emits 06.
REQ-020 Read: stream 52 04 00 00 20, slave returns 0x12345678.
- Required: tx emits 78 56 34 12.
- tx_ready toggling 1/0 shall not duplicate or drop bytes.
REQ-021 Slave wait states:
- hready=0 for 3 cycles in APH: htrans, haddr, hwrite held.
- 2 wait cycles in DPH: data captured on the 3rd cycle.
- Ordering: hgrant withheld 5 cycles keeps hbusreq=1 and htrans=IDLE throughout.
REQ-022 Error and retry:
- Two-cycle ERROR response: tx emits 15 only.
- RETRY response: transfer reissued once with the same address, then OKAY completes normally.
- Unaligned address 0x20000003: haddr=0x20000000.
REQ-023 Reset and junk:
- hreset asserted during DPH: next cycle htrans=0, busy=0, tx_valid=0.
- Junk byte 0x41 in IDLE: consumed with no AHB activity.

Source files
------------

// File: rtl/ahb_byte_master.sv
// Byte-stream command bridge: host sends W/R + little-endian address (+ data for W),
// the block performs one single-word AHB transfer and answers with ACK, NAK or the read word.
module ahb_byte_master #(
    parameter logic [7:0] CMD_WR = 8'h57,
    parameter logic [7:0] CMD_RD = 8'h52,
    parameter logic [7:0] ACK    = 8'h06,
    parameter logic [7:0] NAK    = 8'h15
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        hbusreq,
    input  logic        hgrant,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic        hmasterlock,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_APH  = 3'd4;
    localparam logic [2:0] S_DPH  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    wr_d    = (rx_data == CMD_WR);
                    cnt_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    // Word-aligned transfers only: the low address bits are dropped on capture.
                    addr_d[1:0] = 2'b00;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = wr_q ? S_DATA : S_REQ;
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (hgrant && hready) begin
                    state_d = S_APH;
                end
            end
            S_APH: begin
                if (hready) begin
                    state_d = S_DPH;
                end
            end
            S_DPH: begin
                // Only the hready=1 cycle ends the data phase; RETRY/SPLIT reissue the same transfer.
                if (hready) begin
                    rdata_d = hrdata;
                    err_d   = (hresp == HRESP_ERROR);
                    cnt_d   = 2'd0;
                    state_d = hresp[1] ? S_REQ : S_RESP;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (err_q || wr_q || cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_RESP) begin
            if (err_q) begin
                tx_data = NAK;
            end else if (wr_q) begin
                tx_data = ACK;
            end else begin
                tx_data = rdata_q[{cnt_q, 3'b000} +: 8];
            end
        end
    end

    assign rx_ready    = !hreset && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
    assign tx_valid    = (state_q == S_RESP);
    assign hbusreq     = (state_q == S_REQ);
    assign htrans      = (state_q == S_APH) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr       = addr_q;
    assign hwrite      = (state_q == S_APH) && wr_q;
    assign hwdata      = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign hsize       = 3'b010;
    assign hburst      = 3'b000;
    assign hprot       = 4'b0011;
    assign hmasterlock = 1'b0;

endmodule

// File: tb/tb_ahb_byte_master.sv
// Directed + randomized bench: the bench plays host, arbiter and a word-memory slave, and
// predicts every AHB phase and response byte from the command it sent.
module tb_ahb_byte_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        hbusreq;
    logic        hgrant;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hmasterlock;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int ntxn = 0;
    logic [31:0] mem [logic [29:0]];

    always #5 hclk = ~hclk;

    ahb_byte_master dut (
        .hclk(hclk), .hreset(hreset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite),
        .hwdata(hwdata), .hmasterlock(hmasterlock), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(negedge hclk);
            guard++;
        end
        if (guard >= 50) chk("rx_accept_timeout", 32'd0, 32'd1);
        @(negedge hclk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] bytes [$];
        bytes.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) bytes.push_back(wdata[8*i +: 8]);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (i != bytes.size() - 1) repeat ($urandom_range(0, 1)) @(negedge hclk);
        end
    endtask

    // Arbiter + slave, phase by phase; caller is positioned at the first REQ-cycle negedge.
    task automatic do_ahb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gdly, input int adly, input int ddly,
                          input int retries, input logic [1:0] final_resp);
        logic [1:0] code;
        if ((final_resp != 2'b00 || retries > 0) && ddly == 0) ddly = 1;
        for (int at = 0; at <= retries; at++) begin
            code = (at < retries) ? {1'b1, 1'($urandom_range(0, 1))} : final_resp;
            for (int i = 0; i <= gdly; i++) begin
                chk("req_hbusreq", 32'(hbusreq), 32'd1);
                chk("req_htrans", 32'(htrans), 32'd0);
                chk("req_rx_ready", 32'(rx_ready), 32'd0);
                chk("req_busy", 32'(busy), 32'd1);
                hgrant = (i == gdly);
                hready = 1'b1;
                @(negedge hclk);
            end
            hgrant = 1'b0;
            for (int i = 0; i <= adly; i++) begin
                chk("aph_htrans", 32'(htrans), 32'd2);
                chk("aph_haddr", haddr, {addr[31:2], 2'b00});
                chk("aph_hwrite", 32'(hwrite), 32'(wr));
                chk("aph_hbusreq", 32'(hbusreq), 32'd0);
                hready = (i == adly);
                @(negedge hclk);
            end
            for (int i = 0; i <= ddly; i++) begin
                chk("dph_htrans", 32'(htrans), 32'd0);
                if (wr) chk("dph_hwdata", hwdata, wdata);
                chk("dph_tx_valid", 32'(tx_valid), 32'd0);
                hready = (i == ddly);
                hresp  = (code != 2'b00 && i >= ddly - 1) ? code : 2'b00;
                hrdata = (i == ddly) ? rdata : ~rdata;
                @(negedge hclk);
            end
            hready = 1'b1;
            hresp  = 2'b00;
        end
    endtask

    task automatic collect_tx(input logic [7:0] exp_q [$], input bit toggle);
        logic [7:0] prev;
        bit         stalled;
        int         guard;
        int         k;
        stalled = 1'b0;
        prev    = 8'h00;
        guard   = 0;
        k       = 0;
        chk("resp_first_valid", 32'(tx_valid), 32'd1);
        while (k < exp_q.size() && guard < 200) begin
            if (tx_valid === 1'b1) begin
                if (stalled) chk("tx_stable", 32'(tx_data), 32'(prev));
                tx_ready = toggle ? guard[0] : 1'($urandom_range(0, 1));
                if (tx_ready) begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q[k]));
                    k++;
                    stalled = 1'b0;
                end else begin
                    prev    = tx_data;
                    stalled = 1'b1;
                end
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge hclk);
            guard++;
        end
        if (guard >= 200) chk("tx_timeout", 32'(k), 32'(exp_q.size()));
        tx_ready = 1'b0;
        chk("tx_done_valid", 32'(tx_valid), 32'd0);
        chk("tx_done_busy", 32'(busy), 32'd0);
        chk("idle_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int gdly, input int adly, input int ddly, input int retries,
                       input logic [1:0] final_resp, input bit toggle);
        logic [29:0] word;
        logic [31:0] rdata;
        logic [7:0]  exp_q [$];
        word  = addr[31:2];
        rdata = mem.exists(word) ? mem[word] : $urandom;
        if (!wr) mem[word] = rdata;
        send_cmd(wr, addr, wdata);
        do_ahb(wr, addr, wdata, rdata, gdly, adly, ddly, retries, final_resp);
        if (final_resp == 2'b01) begin
            exp_q.push_back(8'h15);
        end else if (wr) begin
            exp_q.push_back(8'h06);
            mem[word] = wdata;
        end else begin
            for (int i = 0; i < 4; i++) exp_q.push_back(rdata[8*i +: 8]);
        end
        collect_tx(exp_q, toggle);
        ntxn++;
        $display("txn %0d: %s addr=%h data=%h resp=%0d retries=%0d waits=%0d/%0d/%0d",
                 ntxn, wr ? "WR" : "RD", addr, wr ? wdata : rdata, final_resp, retries, gdly, adly, ddly);
    endtask

    initial begin
        hreset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        hgrant = 1'b0; hrdata = 32'h0; hready = 1'b1; hresp = 2'b00;
        repeat (3) @(negedge hclk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_hbusreq", 32'(hbusreq), 32'd0);
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("const_ctrl", {hsize, hburst, hprot, hmasterlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
        hreset = 1'b0;
        @(negedge hclk);
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Basic write and read, immediate grant, zero-wait slave
        txn(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b00, 1'b0);
        mem[30'h0800_0001] = 32'h1234_5678;
        txn(1'b0, 32'h2000_0004, 32'h0, 0, 0, 0, 0, 2'b00, 1'b1);
        // Grant withheld 5, 3 APH waits, 2 DPH waits
        txn(1'b0, 32'h2000_0000, 32'h0, 5, 3, 2, 0, 2'b00, 1'b0);
        // Two-cycle ERROR on write and read
        txn(1'b1, 32'h2000_0008, 32'hCAFE_F00D, 0, 0, 1, 0, 2'b01, 1'b0);
        txn(1'b0, 32'h2000_000C, 32'h0, 1, 1, 1, 0, 2'b01, 1'b1);
        // RETRY once then OKAY; unaligned address
        txn(1'b0, 32'h2000_0004, 32'h0, 0, 0, 1, 1, 2'b00, 1'b0);
        txn(1'b0, 32'h2000_0003, 32'h0, 0, 0, 0, 0, 2'b00, 1'b0);

        // Junk byte in IDLE
        send_byte(8'h41);
        for (int i = 0; i < 3; i++) begin
            chk("junk_busy", 32'(busy), 32'd0);
            chk("junk_hbusreq", 32'(hbusreq), 32'd0);
            chk("junk_htrans", 32'(htrans), 32'd0);
            @(negedge hclk);
        end

        // Reset during the data phase
        send_cmd(1'b0, 32'h2000_0010, 32'h0);
        hgrant = 1'b1; hready = 1'b1;
        @(negedge hclk);
        hgrant = 1'b0;
        @(negedge hclk);
        chk("abort_in_dph_busy", 32'(busy), 32'd1);
        hready = 1'b0; hreset = 1'b1;
        @(negedge hclk);
        chk("abort_htrans", 32'(htrans), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_hbusreq", 32'(hbusreq), 32'd0);
        chk("abort_rx_ready", 32'(rx_ready), 32'd0);
        hreset = 1'b0; hready = 1'b1;
        @(negedge hclk);
        chk("abort_post_rx_ready", 32'(rx_ready), 32'd1);

        // Partial command discarded by reset
        send_byte(8'h52); send_byte(8'h11); send_byte(8'h22);
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        txn(1'b1, 32'h2000_0014, 32'h0BAD_F00D, 0, 0, 0, 0, 2'b00, 1'b0);

        for (int n = 0; n < 24; n++) begin
            txn(1'($urandom_range(0, 1)),
                32'h2000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0) ? 1 : 0,
                ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00,
                1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
